instr_fetch_unit: RTL

Fetch stage of the multicycle RV64 core. Owns the PC register, handshakes with instruction memory, and latches each 32-bit instruction into the instruction register. It also splits the word into decode fields. Its `instr` output feeds the downstream immediate sign-extension block and the control unit; `pc_out` feeds the branch-target adder.

---
 rtl/core_pkg.sv | 27 ++
 rtl/pc_reg.sv | 24 ++
 rtl/instr_fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the multicycle RV64 core.
// Fetch FSM encoding, RV opcode values and the reset nop.
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    function automatic logic pc_aligned(input logic [63:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// 64-bit program counter: load target, step by 4, or hold.
// Load has priority over increment.
module pc_reg #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        incr,
    input  logic [63:0] target,
    output logic [63:0] pc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (incr) begin
            pc <= pc + 64'd4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem handshake, instruction register, decode slices.
// Faults on misaligned PC or a memory response that never arrives.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    input  logic        instr_ack,
    input  logic        pc_load,
    input  logic [63:0] pc_target,
    input  logic        flush,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [63:0] pc_out,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic        fault,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    fetch_state_t   state;
    fetch_state_t   nxt;
    logic [CW-1:0]  cnt;
    logic [63:0]    pc;
    logic           pc_ld;
    logic           pc_inc;
    logic           latch;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pc_ld),
        .incr    (pc_inc),
        .target  (pc_target),
        .pc      (pc)
    );

    always_comb begin
        nxt    = state;
        pc_ld  = 1'b0;
        pc_inc = 1'b0;
        latch  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pc_load) begin
                    pc_ld = 1'b1;
                end else if (fetch_en) begin
                    nxt = pc_aligned(pc) ? ST_REQ : ST_FAULT;
                end
            end
            ST_REQ: begin
                if (flush || pc_load) begin
                    nxt   = ST_IDLE;
                    pc_ld = pc_load;
                end else begin
                    nxt = ST_WAIT;
                end
            end
            // An abandon beats a same-cycle response
            ST_WAIT: begin
                if (flush || pc_load) begin
                    nxt   = ST_IDLE;
                    pc_ld = pc_load;
                end else if (imem_valid) begin
                    latch = 1'b1;
                    nxt   = ST_HOLD;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    nxt = ST_FAULT;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    nxt   = ST_IDLE;
                    pc_ld = pc_load;
                end else if (instr_ack) begin
                    nxt    = ST_IDLE;
                    pc_ld  = pc_load;
                    pc_inc = !pc_load;
                end
            end
            ST_FAULT: begin
                if (flush && pc_load) begin
                    nxt   = ST_IDLE;
                    pc_ld = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == ST_REQ) begin
            cnt <= '0;
        end else if (state == ST_WAIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr  <= NOP_INSTR;
            pc_out <= RESET_PC;
        end else if (latch) begin
            instr  <= imem_rdata;
            pc_out <= pc;
        end
    end

    assign imem_req    = (state == ST_REQ) || (state == ST_WAIT);
    assign imem_addr   = pc;
    assign instr_valid = (state == ST_HOLD);
    assign fault       = (state == ST_FAULT);
    assign busy        = (state != ST_IDLE) && (state != ST_HOLD);

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

endmodule
